// File: rtl/rc4_pkg.sv
// Shared widths, defaults and FSM encoding for the RC4 keystream decrypter.
package rc4_pkg;

    localparam int unsigned MSG_LEN_DEF = 32;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned K_W         = 5;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WT_SI,
        CAP_SI,
        RD_SJ,
        WT_SJ,
        CAP_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WT_F,
        CAP_F,
        WR_DEC,
        DONE
    } state_t;

endpackage

// File: rtl/decrypt_message.sv
// RC4 PRGA over a pre-scheduled S-RAM: swaps S[i]/S[j] and XORs the
// keystream byte with the ciphertext ROM into the plaintext RAM.
module decrypt_message
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              finished,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [K_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [K_W-1:0]    dec_addr,
    output logic [DATA_W-1:0] dec_wdata,
    output logic              dec_wren
);

    localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_i;
    logic [DATA_W-1:0] r_j;
    logic [DATA_W-1:0] r_si;
    logic [DATA_W-1:0] r_sj;
    logic [DATA_W-1:0] r_f;
    logic [K_W-1:0]    r_k;
    logic [ADDR_W-1:0] w_f_addr;

    assign w_f_addr = r_si + r_sj;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath registers: indices, captured S bytes and byte counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i  <= '0;
            r_j  <= '0;
            r_k  <= '0;
            r_si <= '0;
            r_sj <= '0;
            r_f  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i <= 8'd1;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                CAP_SI: begin
                    r_si <= s_rdata;
                    r_j  <= r_j + s_rdata;
                end
                CAP_SJ: r_sj <= s_rdata;
                CAP_F:  r_f  <= s_rdata;
                WR_DEC: begin
                    if (r_k != K_LAST) begin
                        r_k <= r_k + 1'b1;
                        r_i <= r_i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and memory-port decode. Outputs are decoded from registered
    // state, so IDLE (the reset state) presents all-zero ports immediately.
    // Addresses are held through the CAP states so the read stays stable.
    always_comb begin
        w_next    = r_state;
        finished  = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wren    = 1'b0;
        rom_addr  = r_k;
        dec_addr  = '0;
        dec_wdata = '0;
        dec_wren  = 1'b0;
        case (r_state)
            IDLE: begin
                rom_addr = '0;
                if (start) w_next = RD_SI;
            end
            RD_SI:  begin s_addr = r_i; w_next = WT_SI;  end
            WT_SI:  begin s_addr = r_i; w_next = CAP_SI; end
            CAP_SI: begin s_addr = r_i; w_next = RD_SJ;  end
            RD_SJ:  begin s_addr = r_j; w_next = WT_SJ;  end
            WT_SJ:  begin s_addr = r_j; w_next = CAP_SJ; end
            CAP_SJ: begin s_addr = r_j; w_next = WR_SI;  end
            WR_SI: begin
                s_addr  = r_i;
                s_wdata = r_sj;
                s_wren  = 1'b1;
                w_next  = WR_SJ;
            end
            WR_SJ: begin
                s_addr  = r_j;
                s_wdata = r_si;
                s_wren  = 1'b1;
                w_next  = RD_F;
            end
            RD_F:  begin s_addr = w_f_addr; w_next = WT_F;  end
            WT_F:  begin s_addr = w_f_addr; w_next = CAP_F; end
            CAP_F: begin s_addr = w_f_addr; w_next = WR_DEC; end
            WR_DEC: begin
                dec_addr  = r_k;
                dec_wdata = r_f ^ rom_data;
                dec_wren  = 1'b1;
                w_next    = (r_k == K_LAST) ? DONE : RD_SI;
            end
            DONE: begin
                rom_addr = '0;
                finished = 1'b1;
                if (!start) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_decrypt_message.sv
// Directed bench for decrypt_message with behavioural S-RAM, ROM and
// plaintext RAM, plus a plain RC4 PRGA reference for full-message checks.
module tb_decrypt_message;

    localparam int unsigned N     = 32;
    localparam int unsigned LIMIT = 12 * N + 20;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       finished;
    logic [7:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_wren;
    logic [7:0] s_rdata;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [4:0] dec_addr;
    logic [7:0] dec_wdata;
    logic       dec_wren;

    logic [7:0] smem [256];
    logic [7:0] rom  [N];
    logic [7:0] decm [N];
    logic [7:0] ref_out [N];

    int n_cmp = 0;
    int n_bad = 0;

    int         run_cycles;
    int         snap_n0;
    logic [7:0] snap_d0, snap_s1, snap_s255, snap_s2, snap_s3;
    logic       both_wren;

    decrypt_message #(.MSG_LEN(N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .finished (finished),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wren   (s_wren),
        .s_rdata  (s_rdata),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .dec_addr (dec_addr),
        .dec_wdata(dec_wdata),
        .dec_wren (dec_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with one-cycle read latency (read-old-data).
    always @(posedge clk) begin
        s_rdata  <= smem[s_addr];
        rom_data <= rom[rom_addr];
        if (s_wren) smem[s_addr] = s_wdata;
        if (dec_wren) decm[dec_addr] = dec_wdata;
    end

    task automatic init_identity();
        for (int x = 0; x < 256; x++) smem[x] = 8'(x);
    endtask

    task automatic init_mem(input logic [7:0] rom_mul, input logic [7:0] rom_add);
        for (int k = 0; k < N; k++) begin
            rom[k]  = 8'(k) * rom_mul + rom_add;
            decm[k] = 8'hEE;
        end
    endtask

    // Textbook RC4 PRGA over a copy of the current S contents.
    task automatic ref_compute();
        logic [7:0] rs [256];
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) rs[x] = smem[x];
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < N; k++) begin
            i = i + 8'd1;
            j = j + rs[i];
            t = rs[i]; rs[i] = rs[j]; rs[j] = t;
            ref_out[k] = rs[8'(rs[i] + rs[j])] ^ rom[k];
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Raises start (if low) and counts edges after the sampling edge until
    // finished is seen; optionally drops start for 3 cycles at edge glitch_at.
    task automatic do_run(input int glitch_at);
        run_cycles = -1;
        snap_n0    = -1;
        both_wren  = 1'b0;
        if (!start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int n = 1; n <= int'(LIMIT); n++) begin
            @(posedge clk);
            #1;
            if (s_wren && dec_wren) both_wren = 1'b1;
            if (dec_wren && dec_addr == 5'd0) begin
                snap_n0   = n;
                snap_d0   = dec_wdata;
                snap_s1   = smem[1];
                snap_s255 = smem[255];
            end
            if (dec_wren && dec_addr == 5'd1) begin
                snap_s2 = smem[2];
                snap_s3 = smem[3];
            end
            if (glitch_at > 0 && n == glitch_at) start = 1'b0;
            if (glitch_at > 0 && n == glitch_at + 3) start = 1'b1;
            if (finished) begin
                run_cycles = n;
                break;
            end
        end
        n_cmp++;
        if (run_cycles !== 12 * N) begin
            n_bad++;
            $display("FAIL run_latency: got %0d edges, expected %0d", run_cycles, 12 * N);
        end
        n_cmp++;
        if (both_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL wren_exclusive: s_wren and dec_wren high together");
        end
    endtask

    task automatic check_vs_ref(input string tag);
        int errs = 0;
        for (int k = 0; k < N; k++) if (decm[k] !== ref_out[k]) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL %s: %0d bytes differ, dec[0]=%h exp %h dec[31]=%h exp %h",
                     tag, errs, decm[0], ref_out[0], decm[N-1], ref_out[N-1]);
        end
    endtask

    task automatic end_run();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        #3;
        n_cmp++;
        if ({finished, s_wren, dec_wren} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, expected 000", {finished, s_wren, dec_wren});
        end
        n_cmp++;
        if ({s_addr, s_wdata, dec_wdata} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_sbus: got %h, expected 000000", {s_addr, s_wdata, dec_wdata});
        end
        n_cmp++;
        if ({rom_addr, dec_addr} !== 10'h0) begin
            n_bad++;
            $display("FAIL reset_addr: got %h, expected 000", {rom_addr, dec_addr});
        end
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({finished, s_wren, dec_wren} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_hold: got %b, expected 000", {finished, s_wren, dec_wren});
        end
    endtask

    task automatic test_identity_zero_rom();
        logic [7:0] exp4 [4];
        exp4[0] = 8'h02; exp4[1] = 8'h05; exp4[2] = 8'h07; exp4[3] = 8'h0D;
        init_identity();
        init_mem(8'h00, 8'h00);
        ref_compute();
        do_run(0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (decm[k] !== exp4[k]) begin
                n_bad++;
                $display("FAIL ident_dec%0d: got %h, expected %h", k, decm[k], exp4[k]);
            end
        end
        n_cmp++;
        if ({snap_s2, snap_s3} !== 16'h0302) begin
            n_bad++;
            $display("FAIL ident_swap: S[2],S[3]=%h, expected 0302", {snap_s2, snap_s3});
        end
        check_vs_ref("ident_full");
        end_run();
        n_cmp++;
        if (finished !== 1'b0) begin
            n_bad++;
            $display("FAIL ident_release: finished=%b, expected 0", finished);
        end
    endtask

    task automatic test_ascii();
        init_identity();
        init_mem(8'h00, 8'h00);
        rom[0] = 8'h63;
        do_run(0);
        n_cmp++;
        if (snap_d0 !== 8'h61 || snap_n0 !== 11) begin
            n_bad++;
            $display("FAIL ascii_wr: data %h at edge %0d, expected 61 at edge 11", snap_d0, snap_n0);
        end
        n_cmp++;
        if (decm[0] !== 8'h61) begin
            n_bad++;
            $display("FAIL ascii_mem: got %h, expected 61", decm[0]);
        end
        end_run();
    endtask

    task automatic test_swap_wrap();
        init_identity();
        smem[1]   = 8'hFF;
        smem[255] = 8'h01;
        init_mem(8'h00, 8'h5A);
        ref_compute();
        do_run(0);
        n_cmp++;
        if ({snap_s1, snap_s255} !== 16'h01FF) begin
            n_bad++;
            $display("FAIL wrap_swap: S[1],S[255]=%h, expected 01FF", {snap_s1, snap_s255});
        end
        n_cmp++;
        if (decm[0] !== 8'h5A) begin
            n_bad++;
            $display("FAIL wrap_dec0: got %h, expected 5a", decm[0]);
        end
        check_vs_ref("wrap_full");
        end_run();
    endtask

    task automatic test_done_hold();
        init_identity();
        init_mem(8'h03, 8'h11);
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_run(0);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (finished !== 1'b1) begin
            n_bad++;
            $display("FAIL done_hold: finished=%b, expected 1", finished);
        end
        end_run();
        n_cmp++;
        if (finished !== 1'b0) begin
            n_bad++;
            $display("FAIL done_release: finished=%b, expected 0", finished);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({finished, s_wren, s_addr} !== 10'h0) begin
            n_bad++;
            $display("FAIL done_idle: {finished,s_wren,s_addr}=%h, expected 000", {finished, s_wren, s_addr});
        end
    endtask

    task automatic test_mid_reset();
        for (int x = 0; x < 256; x++) smem[x] = 8'(x) * 8'd5 + 8'd3;
        init_mem(8'h07, 8'h01);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (126) @(posedge clk);
        #2;
        n_cmp++;
        if (s_wren !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre: s_wren=%b, expected 1", s_wren);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({finished, s_wren, dec_wren} !== 3'b000) begin
            n_bad++;
            $display("FAIL midrst_async: got %b, expected 000", {finished, s_wren, dec_wren});
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int x = 0; x < 256; x++) smem[x] = 8'(x) * 8'd5 + 8'd3;
        init_mem(8'h07, 8'h01);
        ref_compute();
        do_run(0);
        check_vs_ref("midrst_rerun");
        end_run();
    endtask

    task automatic test_start_glitch();
        for (int x = 0; x < 256; x++) smem[x] = 8'hFF - 8'(x);
        init_mem(8'h0B, 8'h20);
        ref_compute();
        do_run(50);
        check_vs_ref("glitch_full");
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (finished !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_hold: finished=%b, expected 1", finished);
        end
        end_run();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({finished, s_addr} !== 9'h0) begin
            n_bad++;
            $display("FAIL glitch_idle: {finished,s_addr}=%h, expected 000", {finished, s_addr});
        end
        init_identity();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (s_addr !== 8'h01 || finished !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_restart: s_addr=%h finished=%b, expected 01/0", s_addr, finished);
        end
        do_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        init_identity();
        init_mem(8'h00, 8'h00);
        test_reset();
        test_identity_zero_rom();
        test_ascii();
        test_swap_wrap();
        test_done_hold();
        test_mid_reset();
        test_start_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decrypt_message.md
DECRYPT_MESSAGE -- requirements
Module: decrypt_message

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, meaning the number of ciphertext/plaintext bytes processed per run.
REQ-002 SHALL have ports in this order:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  level request to run.
- finished  out  1  high while the run is complete.
- s_addr  out  8  S-RAM address.
- s_wdata  out  8  S-RAM write data.
- s_wren  out  1  S-RAM write enable.
- s_rdata  in  8  S-RAM read data; valid one cycle after s_addr.
- rom_addr  out  5  ciphertext ROM address.
- rom_data  in  8  ciphertext byte; valid one cycle after rom_addr.
- dec_addr  out  5  plaintext RAM address, read later by check_message.
- dec_wdata  out  8  plaintext byte.
- dec_wren  out  1  plaintext RAM write enable.

Function
REQ-003 SHALL implement the RC4 PRGA on an S-RAM that is already key-scheduled. For k = 0..MSG_LEN-1:
- i = i+1
- j = j+S[i]
- swap S[i] and S[j]
- dec[k] = S[(S[i]+S[j]) mod 256] XOR rom[k]
REQ-004 SHALL perform all i, j and index arithmetic modulo 256 on 8 bits. k is 5 bits.
REQ-005 SHALL use FSM states IDLE, RD_SI, WT_SI, CAP_SI, RD_SJ, WT_SJ, CAP_SJ, WR_SI, WR_SJ, RD_F, WT_F, CAP_F, WR_DEC, DONE.
REQ-006 SHALL, in IDLE with start=1, load i=1, j=0 and k=0, then enter RD_SI.
REQ-007 SHALL, in IDLE with start=0, remain in IDLE.
REQ-008 SHALL drive s_addr=i in RD_SI and WT_SI.
REQ-009 SHALL, in CAP_SI, capture si=s_rdata and update j=j+s_rdata.
REQ-010 SHALL drive s_addr=j in RD_SJ and WT_SJ, and capture sj in CAP_SJ.
REQ-011 SHALL perform the swap as follows:
- WR_SI: s_addr=i, s_wdata=sj, s_wren=1.
- WR_SJ: s_addr=j, s_wdata=si, s_wren=1.
REQ-012 SHALL drive s_addr=si+sj in RD_F and WT_F, and capture f in CAP_F.
REQ-013 SHALL hold rom_addr=k during every per-byte state.
REQ-014 SHALL, in WR_DEC, drive dec_addr=k, dec_wdata=f XOR rom_data and dec_wren=1.
REQ-015 SHALL, on leaving WR_DEC:
- if k=MSG_LEN-1, enter DONE;
- otherwise increment k and i and return to RD_SI.
REQ-016 SHALL take exactly 12 cycles per byte. DONE SHALL be entered 12*MSG_LEN edges (384 by default) after the edge on which start was sampled in IDLE.
REQ-017 SHALL drive finished=1 only in DONE.
REQ-018 SHALL remain in DONE while start=1, and return to IDLE on the first edge with start=0.
REQ-019 SHALL ignore start while busy; deasserting start mid-run does not abort the run.
REQ-020 SHALL give the correct result when i=j: the swap is a no-op and f=S[2*si].
REQ-021 SHALL keep s_wren and dec_wren low in every state not named in REQ-011 and REQ-014. Both SHALL never be high together.

Reset
REQ-022 SHALL, on reset_n=0, immediately set:
- state to IDLE;
- finished, s_wren and dec_wren to 0;
- i, j, k, si, sj, f, s_addr, s_wdata, rom_addr, dec_addr and dec_wdata to 0.
REQ-023 SHALL leave S-RAM contents undefined after a mid-run reset. The upstream key schedule must rerun before the next start.

Structure
REQ-024 SHALL place MSG_LEN default, the 8-bit data/address widths and the FSM state enum in shared package rc4_pkg.
REQ-025 SHALL be a single module; no sub-module is natural. Datapath registers and the FSM live together.

Verification
REQ-026 Identity S (S[x]=x), ROM all 0x00 -> dec[0]=0x02, dec[1]=0x05; after byte 1, S[2]=0x03 and S[3]=0x02.
REQ-027 Identity S, rom[0]=0x63 -> dec[0]=0x61 ('a'), written in the WR_DEC cycle with dec_addr=0.
REQ-028 Identity S except S[1]=0xFF, S[255]=0x01 -> j=0xFF, swap gives S[1]=0x01 and S[255]=0xFF, dec[0]=S[0x00] XOR rom[0] = 0x00 XOR rom[0].
REQ-029 start held high from reset -> finished rises 384 cycles after the start sample and stays high; start low -> finished low next edge, then IDLE.
REQ-030 reset_n low during byte 10 -> all wren and finished low asynchronously; after S re-init and a new start, output matches a clean run byte for byte.
REQ-031 start pulsed low during the run -> run completes normally; no restart until start is low in DONE and then high again.
